sprite_draw_fifo: RTL and testbench

SPRITE_DRAW_FIFO -- requirements
Module: sprite_draw_fifo

---
 rtl/sprite_pkg.sv | 23 ++
 rtl/sprite_record_assembler.sv | 65 ++++++
 rtl/sprite_draw_fifo.sv | 107 ++++++++++
 tb/tb_sprite_draw_fifo.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg
//   Shared definitions for the sprite draw queue: default field widths,
//   the packed sprite record layout (id, x, y, scale) and the helper that
//   gives the number of SPI bytes making up one record.
package sprite_pkg;

  localparam int ID_W_DEF    = 8;
  localparam int COORD_W_DEF = 16;
  localparam int SCALE_W_DEF = 8;

  // Field order matches the byte order on the wire: id first, scale last.
  typedef struct packed {
    logic [ID_W_DEF-1:0]    id;
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
    logic [SCALE_W_DEF-1:0] scale;
  } sprite_record_t;

  function automatic int record_bytes(input int id_w, input int coord_w, input int scale_w);
    return (id_w + 2 * coord_w + scale_w) / 8;
  endfunction

endpackage

// File: rtl/sprite_record_assembler.sv
// sprite_record_assembler
//   Collects SPI payload bytes into one sprite record, MSB byte first.
//   Ports:
//     clock, reset      - single clock, synchronous active-high reset
//     clear             - synchronous flush of the partial record
//     byte_valid        - one-cycle strobe qualifying byte_data
//     byte_data         - payload byte
//     enqueue_en        - high while the current command is "draw sprite"
//     record_valid      - high in the cycle whose edge accepts the last byte
//     record            - complete record {id, x, y, scale}, valid with record_valid
module sprite_record_assembler
  import sprite_pkg::*;
#(
  parameter int ID_W    = ID_W_DEF,
  parameter int COORD_W = COORD_W_DEF,
  parameter int SCALE_W = SCALE_W_DEF
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 clear,
  input  logic                                 byte_valid,
  input  logic [7:0]                           byte_data,
  input  logic                                 enqueue_en,
  output logic                                 record_valid,
  output logic [ID_W+2*COORD_W+SCALE_W-1:0]    record
);

  localparam int N       = record_bytes(ID_W, COORD_W, SCALE_W);
  localparam int REC_W   = 8 * N;
  localparam int SHIFT_W = REC_W - 8;
  localparam int IDX_W   = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [IDX_W-1:0]   byte_idx;
  logic [SHIFT_W-1:0] shift;
  logic               accept;
  logic               last_byte;

  assign accept    = byte_valid && enqueue_en;
  assign last_byte = (byte_idx == LAST_IDX);

  // The final byte is taken straight from the input so the record can be
  // written into the queue at the same edge that accepts it.
  assign record_valid = accept && last_byte;
  assign record       = {shift, byte_data};

  // Dropping enqueue_en abandons any partial record by restarting the index.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      byte_idx <= '0;
    end else if (!enqueue_en) begin
      byte_idx <= '0;
    end else if (byte_valid) begin
      byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
    end
  end

  // No reset needed: a restarted index overwrites every stale byte.
  always_ff @(posedge clock) begin
    if (accept) begin
      shift <= {shift[SHIFT_W-9:0], byte_data};
    end
  end

endmodule

// File: rtl/sprite_draw_fifo.sv
// sprite_draw_fifo
//   Queue of sprite draw records assembled from SPI payload bytes, with a
//   first-word fall-through head.
//   Ports:
//     clock, reset              - single clock, synchronous active-high reset
//     byte_valid, byte_data     - incoming payload byte strobe and value
//     enqueue_en                - current command is "draw sprite"
//     clear                     - flush queue, assembler and overflow flag
//     dequeue                   - pop head record (ignored when empty)
//     is_empty, is_full, count  - occupancy, derived from registered count
//     overflow                  - sticky: a completed record was dropped
//     sprite_id/x/y/scale       - head record fields, zero when empty
module sprite_draw_fifo
  import sprite_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ID_W    = ID_W_DEF,
  parameter int COORD_W = COORD_W_DEF,
  parameter int SCALE_W = SCALE_W_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      byte_valid,
  input  logic [7:0]                byte_data,
  input  logic                      enqueue_en,
  input  logic                      clear,
  input  logic                      dequeue,
  output logic                      is_empty,
  output logic                      is_full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [ID_W-1:0]           sprite_id,
  output logic [COORD_W-1:0]        sprite_x,
  output logic [COORD_W-1:0]        sprite_y,
  output logic [SCALE_W-1:0]        sprite_scale
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int REC_W = ID_W + 2 * COORD_W + SCALE_W;
  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [REC_W-1:0] new_record;
  logic [REC_W-1:0] head;
  logic             record_valid;
  logic             pop;
  logic             push;
  logic             drop;

  sprite_record_assembler #(
    .ID_W    (ID_W),
    .COORD_W (COORD_W),
    .SCALE_W (SCALE_W)
  ) u_assembler (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .enqueue_en   (enqueue_en),
    .record_valid (record_valid),
    .record       (new_record)
  );

  assign is_empty = (count == '0);
  assign is_full  = (count == COUNT_FULL);

  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign pop  = dequeue && !is_empty;
  assign push = record_valid && (!is_full || pop);
  assign drop = record_valid && is_full && !pop;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage has no reset so it can map to distributed RAM.
  always_ff @(posedge clock) begin
    if (push && !reset && !clear) begin
      mem[wr_ptr] <= new_record;
    end
  end

  assign head = is_empty ? '0 : mem[rd_ptr];

  assign sprite_id    = head[REC_W-1 -: ID_W];
  assign sprite_x     = head[REC_W-ID_W-1 -: COORD_W];
  assign sprite_y     = head[SCALE_W +: COORD_W];
  assign sprite_scale = head[SCALE_W-1:0];

endmodule

// File: tb/tb_sprite_draw_fifo.sv
// tb_sprite_draw_fifo
//   Directed bench for sprite_draw_fifo at default parameters
//   (DEPTH 16, 6-byte records).
module tb_sprite_draw_fifo;
  import sprite_pkg::*;

  logic        clock;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        enqueue_en;
  logic        clear;
  logic        dequeue;
  logic        is_empty;
  logic        is_full;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  sprite_id;
  logic [15:0] sprite_x;
  logic [15:0] sprite_y;
  logic [7:0]  sprite_scale;

  int checks   = 0;
  int failures = 0;

  sprite_draw_fifo dut (
    .clock        (clock),
    .reset        (reset),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .enqueue_en   (enqueue_en),
    .clear        (clear),
    .dequeue      (dequeue),
    .is_empty     (is_empty),
    .is_full      (is_full),
    .count        (count),
    .overflow     (overflow),
    .sprite_id    (sprite_id),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .sprite_scale (sprite_scale)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change #1 after a rising edge; outputs are read just before the next.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic send_record(input logic [7:0] id, input logic [15:0] x,
                             input logic [15:0] y, input logic [7:0] sc,
                             input bit pop_last);
    enqueue_en = 1'b1;
    send_byte(id);
    send_byte(x[15:8]);
    send_byte(x[7:0]);
    send_byte(y[15:8]);
    send_byte(y[7:0]);
    if (pop_last) dequeue = 1'b1;
    send_byte(sc);
    dequeue = 1'b0;
  endtask

  task automatic pop_one();
    dequeue = 1'b1;
    tick();
    dequeue = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (is_empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%0b exp=1", is_empty); end
    checks++; if (is_full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%0b exp=0", is_full); end
    checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%0b exp=0", overflow); end
    checks++; if ({sprite_id, sprite_x, sprite_y, sprite_scale} !== 48'h0) begin failures++; $display("[TB] FAIL reset_head got=%h exp=0", {sprite_id, sprite_x, sprite_y, sprite_scale}); end
  endtask

  task automatic test_single_record();
    enqueue_en = 1'b1;
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h20);
    checks++; if (is_empty !== 1'b1) begin failures++; $display("[TB] FAIL single_before_last got=%0b exp=1", is_empty); end
    send_byte(8'h03);
    checks++; if (is_empty !== 1'b0) begin failures++; $display("[TB] FAIL single_empty got=%0b exp=0", is_empty); end
    checks++; if (count !== 5'd1) begin failures++; $display("[TB] FAIL single_count got=%0d exp=1", count); end
    checks++; if (sprite_id !== 8'h05) begin failures++; $display("[TB] FAIL single_id got=%h exp=05", sprite_id); end
    checks++; if (sprite_x !== 16'h0010) begin failures++; $display("[TB] FAIL single_x got=%h exp=0010", sprite_x); end
    checks++; if (sprite_y !== 16'h0020) begin failures++; $display("[TB] FAIL single_y got=%h exp=0020", sprite_y); end
    checks++; if (sprite_scale !== 8'h03) begin failures++; $display("[TB] FAIL single_scale got=%h exp=03", sprite_scale); end
    pop_one();
    checks++; if (is_empty !== 1'b1 || sprite_id !== 8'h00) begin failures++; $display("[TB] FAIL single_pop got=%0b/%h exp=1/00", is_empty, sprite_id); end
    pop_one();
    checks++; if (count !== 5'd0 || overflow !== 1'b0) begin failures++; $display("[TB] FAIL empty_pop got=%0d/%0b exp=0/0", count, overflow); end
    enqueue_en = 1'b0;
  endtask

  task automatic test_partial_discard();
    enqueue_en = 1'b1;
    send_byte(8'h09); send_byte(8'hAA); send_byte(8'hBB);
    enqueue_en = 1'b0;
    tick();
    send_record(8'h07, 16'h0001, 16'h0002, 8'h01, 1'b0);
    checks++; if (count !== 5'd1) begin failures++; $display("[TB] FAIL partial_count got=%0d exp=1", count); end
    checks++; if (sprite_id !== 8'h07 || sprite_x !== 16'h0001 || sprite_y !== 16'h0002 || sprite_scale !== 8'h01) begin
      failures++; $display("[TB] FAIL partial_head got=%h %h %h %h exp=07 0001 0002 01", sprite_id, sprite_x, sprite_y, sprite_scale); end
    // Bytes arriving with enqueue_en low must be ignored.
    enqueue_en = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'hE0 + 8'(i));
    checks++; if (count !== 5'd1) begin failures++; $display("[TB] FAIL no_enqueue_count got=%0d exp=1", count); end
    pop_one();
    checks++; if (is_empty !== 1'b1) begin failures++; $display("[TB] FAIL partial_drain got=%0b exp=1", is_empty); end
  endtask

  task automatic test_overflow_order();
    for (int i = 0; i < 17; i++) send_record(8'(i), {8'h10, 8'(i)}, {8'h20, 8'(i)}, 8'(i), 1'b0);
    enqueue_en = 1'b0;
    checks++; if (is_full !== 1'b1) begin failures++; $display("[TB] FAIL ovf_full got=%0b exp=1", is_full); end
    checks++; if (count !== 5'd16) begin failures++; $display("[TB] FAIL ovf_count got=%0d exp=16", count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag got=%0b exp=1", overflow); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (sprite_id !== 8'(i) || sprite_x !== {8'h10, 8'(i)} || sprite_y !== {8'h20, 8'(i)} || sprite_scale !== 8'(i)) begin
        failures++; $display("[TB] FAIL ovf_order[%0d] got=%h %h %h %h", i, sprite_id, sprite_x, sprite_y, sprite_scale); end
      pop_one();
    end
    checks++; if (is_empty !== 1'b1 || {sprite_id, sprite_x, sprite_y, sprite_scale} !== 48'h0) begin
      failures++; $display("[TB] FAIL ovf_drained got=%0b/%h exp=1/0", is_empty, {sprite_id, sprite_x, sprite_y, sprite_scale}); end
  endtask

  task automatic test_full_push_pop();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (count !== 5'd0 || overflow !== 1'b0) begin failures++; $display("[TB] FAIL clear_state got=%0d/%0b exp=0/0", count, overflow); end
    for (int i = 0; i < 16; i++) send_record(8'h40 + 8'(i), 16'h0100, 16'h0200, 8'h01, 1'b0);
    checks++; if (is_full !== 1'b1 || overflow !== 1'b0) begin failures++; $display("[TB] FAIL fill_state got=%0b/%0b exp=1/0", is_full, overflow); end
    send_record(8'h99, 16'h1234, 16'h5678, 8'h9A, 1'b1);
    enqueue_en = 1'b0;
    checks++; if (count !== 5'd16) begin failures++; $display("[TB] FAIL fullpp_count got=%0d exp=16", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL fullpp_overflow got=%0b exp=0", overflow); end
    checks++; if (sprite_id !== 8'h41) begin failures++; $display("[TB] FAIL fullpp_head got=%h exp=41", sprite_id); end
    for (int i = 0; i < 15; i++) pop_one();
    checks++; if (count !== 5'd1 || sprite_id !== 8'h99 || sprite_x !== 16'h1234 || sprite_y !== 16'h5678 || sprite_scale !== 8'h9A) begin
      failures++; $display("[TB] FAIL fullpp_tail got=%0d %h %h %h %h exp=1 99 1234 5678 9a", count, sprite_id, sprite_x, sprite_y, sprite_scale); end
    pop_one();
  endtask

  task automatic test_wrap();
    sprite_record_t sb[$];
    sprite_record_t rec;
    for (int i = 0; i < 40; i++) begin
      rec = '{id: 8'(i + 100), x: 16'(i * 7), y: 16'(16'hF000 + i), scale: 8'(i ^ 8'h5A)};
      send_record(rec.id, rec.x, rec.y, rec.scale, 1'b0);
      sb.push_back(rec);
      if (sb.size() == 3) begin
        checks++; if ({sprite_id, sprite_x, sprite_y, sprite_scale} !== sb[0] || count !== 5'd3) begin
          failures++; $display("[TB] FAIL wrap_head[%0d] got=%h cnt=%0d exp=%h cnt=3", i, {sprite_id, sprite_x, sprite_y, sprite_scale}, count, sb[0]); end
        pop_one();
        void'(sb.pop_front());
      end
    end
    enqueue_en = 1'b0;
    while (sb.size() > 0) begin
      checks++; if ({sprite_id, sprite_x, sprite_y, sprite_scale} !== sb[0]) begin
        failures++; $display("[TB] FAIL wrap_drain got=%h exp=%h", {sprite_id, sprite_x, sprite_y, sprite_scale}, sb[0]); end
      pop_one();
      void'(sb.pop_front());
    end
    checks++; if (is_empty !== 1'b1) begin failures++; $display("[TB] FAIL wrap_empty got=%0b exp=1", is_empty); end
  endtask

  task automatic test_clear_and_reset();
    for (int i = 0; i < 17; i++) send_record(8'(i), 16'h0, 16'h0, 8'h0, 1'b0);
    checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL pre_clear_overflow got=%0b exp=1", overflow); end
    // clear together with an accepted-looking byte: the byte must be ignored.
    clear = 1'b1; byte_valid = 1'b1; byte_data = 8'h55; dequeue = 1'b1;
    tick();
    clear = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; dequeue = 1'b0;
    checks++; if (count !== 5'd0 || overflow !== 1'b0 || is_empty !== 1'b1) begin
      failures++; $display("[TB] FAIL clear_prio got=%0d/%0b/%0b exp=0/0/1", count, overflow, is_empty); end
    send_byte(8'h11); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
    checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL clear_byte_dropped got=%0d exp=0", count); end
    send_byte(8'h03);
    checks++; if (count !== 5'd1 || sprite_id !== 8'h11 || sprite_x !== 16'h0001 || sprite_y !== 16'h0002 || sprite_scale !== 8'h03) begin
      failures++; $display("[TB] FAIL clear_next_rec got=%0d %h %h %h %h exp=1 11 0001 0002 03", count, sprite_id, sprite_x, sprite_y, sprite_scale); end

    for (int i = 0; i < 16; i++) send_record(8'(i), 16'h0, 16'h0, 8'h0, 1'b0);
    checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_overflow got=%0b exp=1", overflow); end
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    reset = 1'b1; byte_valid = 1'b1; byte_data = 8'hA4; clear = 1'b0;
    tick();
    reset = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    checks++; if (count !== 5'd0 || overflow !== 1'b0 || is_empty !== 1'b1 || sprite_id !== 8'h00) begin
      failures++; $display("[TB] FAIL reset_mid got=%0d/%0b/%0b/%h exp=0/0/1/00", count, overflow, is_empty, sprite_id); end
    send_record(8'h22, 16'hBEEF, 16'hCAFE, 8'h44, 1'b0);
    enqueue_en = 1'b0;
    checks++; if (count !== 5'd1 || sprite_id !== 8'h22 || sprite_x !== 16'hBEEF || sprite_y !== 16'hCAFE || sprite_scale !== 8'h44) begin
      failures++; $display("[TB] FAIL reset_next_rec got=%0d %h %h %h %h exp=1 22 beef cafe 44", count, sprite_id, sprite_x, sprite_y, sprite_scale); end
  endtask

  initial begin
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    enqueue_en = 1'b0;
    clear      = 1'b0;
    dequeue    = 1'b0;
    test_reset();
    test_single_record();
    test_partial_discard();
    test_overflow_order();
    test_full_push_pop();
    test_wrap();
    test_clear_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
